// File: rtl/traffic_sensor_if.sv
// Vehicle-detector front end: synchronises and debounces loop sensors, latches sticky
// per-direction service requests, counts waiting cars and flags a North/East green conflict.
module traffic_sensor_if #(
    parameter int DEB_MAX = 500000,
    parameter int CNT_W   = 4
) (
    input  logic             CLOCK_50,
    input  logic             KEY,
    input  logic [1:0]       SENSE,
    input  logic [2:0]       LED_N,
    input  logic [2:0]       LED_E,
    output logic [1:0]       REQ,
    output logic [CNT_W-1:0] CNT_N,
    output logic [CNT_W-1:0] CNT_E,
    output logic             CONFLICT
);

    localparam int             DW       = $clog2(DEB_MAX + 1);
    localparam logic [DW-1:0]  DEB_LAST = DW'(DEB_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [2:0]     LED_GREEN = 3'b001;

    // Reset asserts asynchronously but releases only after two clock edges.
    logic rst_meta_d, rst_meta_q;
    logic rst_sync_d, rst_sync_q;

    always_comb begin
        rst_meta_d = 1'b1;
        rst_sync_d = rst_meta_q;
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= rst_meta_d;
            rst_sync_q <= rst_sync_d;
        end
    end

    logic [1:0]       sync0_d, sync0_q;
    logic [1:0]       sync1_d, sync1_q;
    logic [1:0]       lvl_d, lvl_q;
    logic [1:0]       lvl_prev_d, lvl_prev_q;
    logic [1:0]       green_prev_d, green_prev_q;
    logic [1:0]       req_d, req_q;
    logic             conflict_d, conflict_q;
    logic [DW-1:0]    deb_cnt_d [2];
    logic [DW-1:0]    deb_cnt_q [2];
    logic [CNT_W-1:0] car_cnt_d [2];
    logic [CNT_W-1:0] car_cnt_q [2];

    logic [1:0] green;
    logic [1:0] arrival;
    logic [1:0] green_exit;

    always_comb begin
        green[0]   = (LED_N == LED_GREEN);
        green[1]   = (LED_E == LED_GREEN);
        arrival    = lvl_q & ~lvl_prev_q;
        green_exit = green_prev_q & ~green;
    end

    // Next-state logic for synchroniser, debouncer, requests and counters.
    always_comb begin
        sync0_d      = SENSE;
        sync1_d      = sync0_q;
        lvl_d        = lvl_q;
        lvl_prev_d   = lvl_q;
        green_prev_d = green;
        req_d        = req_q;
        conflict_d   = conflict_q | (green[0] & green[1]);
        for (int i = 0; i < 2; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            car_cnt_d[i] = car_cnt_q[i];

            if (sync1_q[i] == lvl_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                lvl_d[i]     = sync1_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end

            // Serving green wins over a same-cycle arrival; a car still present at green end re-requests.
            if (green[i]) begin
                req_d[i] = 1'b0;
            end else if (arrival[i] || (green_exit[i] && lvl_q[i])) begin
                req_d[i] = 1'b1;
            end

            if (green[i]) begin
                car_cnt_d[i] = '0;
            end else if (arrival[i] && (car_cnt_q[i] != CNT_SAT)) begin
                car_cnt_d[i] = car_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            sync0_q      <= '0;
            sync1_q      <= '0;
            lvl_q        <= '0;
            lvl_prev_q   <= '0;
            green_prev_q <= '0;
            req_q        <= '0;
            conflict_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
                car_cnt_q[i] <= '0;
            end
        end else begin
            sync0_q      <= sync0_d;
            sync1_q      <= sync1_d;
            lvl_q        <= lvl_d;
            lvl_prev_q   <= lvl_prev_d;
            green_prev_q <= green_prev_d;
            req_q        <= req_d;
            conflict_q   <= conflict_d;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                car_cnt_q[i] <= car_cnt_d[i];
            end
        end
    end

    assign REQ      = req_q;
    assign CNT_N    = car_cnt_q[0];
    assign CNT_E    = car_cnt_q[1];
    assign CONFLICT = conflict_q;

endmodule

// File: tb/tb_traffic_sensor_if.sv
// Directed bench for traffic_sensor_if with a short debounce window (DEB_MAX=4).
module tb_traffic_sensor_if;

    logic       clk;
    logic       key;
    logic [1:0] sense;
    logic [2:0] ledN;
    logic [2:0] ledE;
    logic [1:0] req;
    logic [3:0] cntN;
    logic [3:0] cntE;
    logic       conflict;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [1:0] sense;
        logic [2:0] ledN;
        logic [2:0] ledE;
        int         cycles;
        logic [1:0] expReq;
        logic [3:0] expCntN;
        logic [3:0] expCntE;
        logic       expConf;
        string      name;
    } vec_t;

    vec_t tableA[$];
    vec_t tableB[$];

    traffic_sensor_if #(.DEB_MAX(4), .CNT_W(4)) dut (
        .CLOCK_50(clk),
        .KEY(key),
        .SENSE(sense),
        .LED_N(ledN),
        .LED_E(ledE),
        .REQ(req),
        .CNT_N(cntN),
        .CNT_E(cntE),
        .CONFLICT(conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives inputs at a falling edge and then lets the given number of cycles elapse.
    task automatic applyStimulus(input logic [1:0] s, input logic [2:0] n, input logic [2:0] e,
                                 input int cycles);
        sense = s;
        ledN  = n;
        ledE  = e;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [1:0] expReq, input logic [3:0] expN,
                               input logic [3:0] expE, input logic expConf);
        checkCount++;
        if (req === expReq && cntN === expN && cntE === expE && conflict === expConf) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got REQ=%b CNT_N=%0d CNT_E=%0d CONFLICT=%b, expected REQ=%b CNT_N=%0d CNT_E=%0d CONFLICT=%b",
                     name, req, cntN, cntE, conflict, expReq, expN, expE, expConf);
        end
    endtask

    task automatic runTable(input vec_t vecs[$]);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sense, vecs[i].ledN, vecs[i].ledE, vecs[i].cycles);
            checkOutput(vecs[i].name, vecs[i].expReq, vecs[i].expCntN, vecs[i].expCntE, vecs[i].expConf);
        end
    endtask

    initial begin
        tableA.push_back('{2'b10, 3'b001, 3'b100, 3,  2'b00, 4'd0, 4'd0, 1'b0, "glitch3_high"});
        tableA.push_back('{2'b00, 3'b001, 3'b100, 10, 2'b00, 4'd0, 4'd0, 1'b0, "glitch3_rejected"});
        tableA.push_back('{2'b10, 3'b001, 3'b100, 1,  2'b00, 4'd0, 4'd0, 1'b0, "glitch1_high"});
        tableA.push_back('{2'b00, 3'b001, 3'b100, 10, 2'b00, 4'd0, 4'd0, 1'b0, "glitch1_rejected"});

        tableB.push_back('{2'b00, 3'b001, 3'b100, 2,  2'b00, 4'd0, 4'd0, 1'b0, "n_clear"});
        tableB.push_back('{2'b00, 3'b100, 3'b100, 2,  2'b00, 4'd0, 4'd0, 1'b0, "both_red_idle"});
        tableB.push_back('{2'b11, 3'b100, 3'b100, 6,  2'b00, 4'd0, 4'd0, 1'b0, "both_pre_edge"});
        tableB.push_back('{2'b11, 3'b100, 3'b100, 1,  2'b11, 4'd1, 4'd1, 1'b0, "both_arrive"});
        tableB.push_back('{2'b11, 3'b100, 3'b011, 3,  2'b11, 4'd1, 4'd1, 1'b0, "illegal_not_green"});
        tableB.push_back('{2'b11, 3'b100, 3'b001, 1,  2'b01, 4'd1, 4'd0, 1'b0, "e_green_clear"});
        tableB.push_back('{2'b11, 3'b100, 3'b100, 1,  2'b11, 4'd1, 4'd0, 1'b0, "e_exit_rereq"});
        tableB.push_back('{2'b11, 3'b001, 3'b001, 1,  2'b00, 4'd0, 4'd0, 1'b1, "conflict_set"});
        tableB.push_back('{2'b11, 3'b100, 3'b100, 1,  2'b11, 4'd0, 4'd0, 1'b1, "conflict_exit"});
        tableB.push_back('{2'b00, 3'b100, 3'b100, 10, 2'b11, 4'd0, 4'd0, 1'b1, "conflict_sticky"});
        tableB.push_back('{2'b00, 3'b001, 3'b100, 2,  2'b10, 4'd0, 4'd0, 1'b1, "n_clear_pre_rst"});
        tableB.push_back('{2'b00, 3'b100, 3'b100, 2,  2'b10, 4'd0, 4'd0, 1'b1, "req_10"});

        key   = 1'b0;
        sense = 2'b00;
        ledN  = 3'b001;
        ledE  = 3'b100;
        repeat (3) @(negedge clk);
        checkOutput("in_reset", 2'b00, 4'd0, 4'd0, 1'b0);
        key = 1'b1;
        for (int i = 0; i < 5; i++) begin
            repeat (10) @(negedge clk);
            checkOutput($sformatf("idle_%0d", i), 2'b00, 4'd0, 4'd0, 1'b0);
        end

        runTable(tableA);

        // East arrival latency, clear on green, re-request on green exit
        applyStimulus(2'b10, 3'b100, 3'b100, 6);
        checkOutput("e_edge_minus1", 2'b00, 4'd0, 4'd0, 1'b0);
        applyStimulus(2'b10, 3'b100, 3'b100, 1);
        checkOutput("e_arrive", 2'b10, 4'd0, 4'd1, 1'b0);
        applyStimulus(2'b10, 3'b100, 3'b001, 1);
        checkOutput("e_green_1clk", 2'b00, 4'd0, 4'd0, 1'b0);
        applyStimulus(2'b10, 3'b100, 3'b001, 5);
        checkOutput("e_green_hold", 2'b00, 4'd0, 4'd0, 1'b0);
        applyStimulus(2'b10, 3'b100, 3'b100, 1);
        checkOutput("e_exit_present", 2'b10, 4'd0, 4'd0, 1'b0);
        applyStimulus(2'b00, 3'b100, 3'b100, 10);
        checkOutput("e_depart_hold", 2'b10, 4'd0, 4'd0, 1'b0);
        applyStimulus(2'b00, 3'b100, 3'b001, 2);
        applyStimulus(2'b00, 3'b100, 3'b100, 2);
        checkOutput("e_exit_absent", 2'b00, 4'd0, 4'd0, 1'b0);

        // North pulses during green are served immediately, then saturate once red
        applyStimulus(2'b00, 3'b001, 3'b100, 2);
        for (int p = 0; p < 3; p++) begin
            applyStimulus(2'b01, 3'b001, 3'b100, 6);
            checkOutput($sformatf("n_green_hi_%0d", p), 2'b00, 4'd0, 4'd0, 1'b0);
            applyStimulus(2'b00, 3'b001, 3'b100, 8);
            checkOutput($sformatf("n_green_lo_%0d", p), 2'b00, 4'd0, 4'd0, 1'b0);
        end
        applyStimulus(2'b00, 3'b100, 3'b100, 2);
        checkOutput("n_red_idle", 2'b00, 4'd0, 4'd0, 1'b0);
        for (int p = 1; p <= 20; p++) begin
            applyStimulus(2'b01, 3'b100, 3'b100, 6);
            applyStimulus(2'b00, 3'b100, 3'b100, 8);
            checkOutput($sformatf("n_sat_%0d", p), 2'b01, (p > 15) ? 4'd15 : 4'(p), 4'd0, 1'b0);
        end

        runTable(tableB);

        // Asynchronous reset in the middle of a North debounce with REQ=10
        applyStimulus(2'b01, 3'b100, 3'b100, 3);
        #2 key = 1'b0;
        #1 checkOutput("async_reset", 2'b00, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        applyStimulus(2'b01, 3'b100, 3'b100, 3);
        checkOutput("reset_held", 2'b00, 4'd0, 4'd0, 1'b0);
        key = 1'b1;
        applyStimulus(2'b00, 3'b100, 3'b100, 4);
        checkOutput("after_release", 2'b00, 4'd0, 4'd0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
